// File: rtl/mult_v3_pkg.sv
// Shared types and width/constant helpers for the mult_v3 per-channel gain stage.
// Optional signed offsets are enabled with the MULT_V3_OFFSET_EN macro.
package mult_v3_pkg;

    // Pipeline depth from input pins to output registers.
    localparam int unsigned Latency = 3;

    typedef struct packed {
        logic de;
        logic hs;
        logic vs;
    } sync_t;

    localparam sync_t SyncReset = '{de: 1'b0, hs: 1'b1, vs: 1'b0};

    function automatic int unsigned coe_unity(int unsigned coe_frac);
        return 32'd1 << coe_frac;
    endfunction

    // Half an LSB of the integer result; nothing to add for an integer-only coefficient.
    function automatic int unsigned round_const(int unsigned coe_frac);
        return (coe_frac == 0) ? 32'd0 : (32'd1 << (coe_frac - 1));
    endfunction

    function automatic int unsigned prod_width(int unsigned pix_w, int unsigned coe_w);
        return pix_w + coe_w;
    endfunction

    // One guard bit for the rounding add, minus the dropped fraction.
    function automatic int unsigned round_width(int unsigned pix_w, int unsigned coe_w,
                                                int unsigned coe_frac);
        return pix_w + coe_w + 1 - coe_frac;
    endfunction

endpackage

// File: rtl/mult_v3_ch.sv
// One channel of mult_v3: multiply, round half-up, optional offset, clamp to pixel range.
// Offset path exists only when MULT_V3_OFFSET_EN is defined.
module mult_v3_ch
    import mult_v3_pkg::*;
#(
    parameter int unsigned PIXEL_WIDTH = 8,
    parameter int unsigned COE_WIDTH   = 16,
    parameter int unsigned COE_FRAC    = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [PIXEL_WIDTH-1:0] pix_i,
    input  logic [COE_WIDTH-1:0]   coe_i,
`ifdef MULT_V3_OFFSET_EN
    input  logic [PIXEL_WIDTH:0]   off_i,
`endif
    output logic [PIXEL_WIDTH-1:0] pix_o,
    output logic                   sat_o
);

    localparam int unsigned ProdW = prod_width(PIXEL_WIDTH, COE_WIDTH);
    localparam int unsigned RndW  = round_width(PIXEL_WIDTH, COE_WIDTH, COE_FRAC);
    localparam logic [ProdW:0] RndConst = (ProdW + 1)'(round_const(COE_FRAC));

    logic [PIXEL_WIDTH-1:0] pix_q;
    logic [COE_WIDTH-1:0]   coe_q;
    logic [ProdW-1:0]       prod;
    logic [ProdW:0]         prod_rnd;
    logic [RndW-1:0]        rnd;
    logic [PIXEL_WIDTH-1:0] out_d, out_q;
    logic                   sat_d, sat_q;

    assign prod     = ProdW'(pix_q) * ProdW'(coe_q);
    assign prod_rnd = {1'b0, prod} + RndConst;
    assign rnd      = prod_rnd[ProdW:COE_FRAC];

`ifdef MULT_V3_OFFSET_EN
    // Two extra bits: sign, plus headroom for a positive offset on a maximal product.
    localparam int unsigned SumW = RndW + 2;

    logic [PIXEL_WIDTH:0]   off_q;
    logic signed [SumW-1:0] sum_d, sum_q;

    assign sum_d = $signed({2'b00, rnd})
                 + $signed({{(SumW - PIXEL_WIDTH - 1){off_q[PIXEL_WIDTH]}}, off_q});

    always_comb begin
        out_d = sum_q[PIXEL_WIDTH-1:0];
        sat_d = 1'b0;
        if (sum_q[SumW-1]) begin
            out_d = '0;
            sat_d = 1'b1;
        end else if (|sum_q[SumW-2:PIXEL_WIDTH]) begin
            out_d = '1;
            sat_d = 1'b1;
        end
    end
`else
    logic [RndW-1:0] rnd_q;

    always_comb begin
        out_d = rnd_q[PIXEL_WIDTH-1:0];
        sat_d = 1'b0;
        if (|rnd_q[RndW-1:PIXEL_WIDTH]) begin
            out_d = '1;
            sat_d = 1'b1;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            pix_q <= '0;
            coe_q <= '0;
            out_q <= '0;
            sat_q <= 1'b0;
`ifdef MULT_V3_OFFSET_EN
            off_q <= '0;
            sum_q <= '0;
`else
            rnd_q <= '0;
`endif
        end else begin
            pix_q <= pix_i;
            coe_q <= coe_i;
            out_q <= out_d;
            sat_q <= sat_d;
`ifdef MULT_V3_OFFSET_EN
            off_q <= off_i;
            sum_q <= sum_d;
`else
            rnd_q <= rnd;
`endif
        end
    end

    assign pix_o = out_q;
    assign sat_o = sat_q;

endmodule

// File: rtl/mult_v3.sv
// Per-channel fixed-point gain for a de/hs/vs pixel stream with frame-synchronous updates
// and per-frame saturation count. MULT_V3_OFFSET_EN adds shadowed signed offsets (off_i).
module mult_v3
    import mult_v3_pkg::*;
#(
    parameter int unsigned PIXEL_WIDTH   = 8,
    parameter int unsigned CH_COUNT      = 3,
    parameter int unsigned COE_WIDTH     = 16,
    parameter int unsigned COE_FRAC      = 10,
    parameter int unsigned SAT_CNT_WIDTH = 24
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [CH_COUNT*COE_WIDTH-1:0]     coe_i,
    input  logic                              coe_upd_i,
    input  logic [CH_COUNT*PIXEL_WIDTH-1:0]   di_i,
    input  logic                              de_i,
    input  logic                              hs_i,
    input  logic                              vs_i,
`ifdef MULT_V3_OFFSET_EN
    input  logic [CH_COUNT*(PIXEL_WIDTH+1)-1:0] off_i,
`endif
    output logic [CH_COUNT*PIXEL_WIDTH-1:0]   do_o,
    output logic                              de_o,
    output logic                              hs_o,
    output logic                              vs_o,
    output logic                              coe_pend_o,
    output logic [SAT_CNT_WIDTH-1:0]          sat_cnt_o,
    output logic                              sat_vld_o
);

    localparam int unsigned CoeBusW = CH_COUNT * COE_WIDTH;
    localparam logic [COE_WIDTH-1:0] CoeUnity = COE_WIDTH'(coe_unity(COE_FRAC));

    sync_t                    sync_q [Latency];
    logic                     vs_in_q;
    logic                     vs_rise;
    logic [CoeBusW-1:0]       coe_act_d, coe_act_q;
    logic [CoeBusW-1:0]       coe_shd_d, coe_shd_q;
    logic                     pend_d, pend_q;
    logic [CH_COUNT-1:0]      ch_sat;
    logic                     vs_out_q;
    logic                     vs_fall;
    logic                     sat_hit;
    logic [SAT_CNT_WIDTH-1:0] acc_inc;
    logic [SAT_CNT_WIDTH-1:0] acc_d, acc_q;
    logic [SAT_CNT_WIDTH-1:0] sat_cnt_d, sat_cnt_q;
    logic                     sat_vld_d, sat_vld_q;

`ifdef MULT_V3_OFFSET_EN
    localparam int unsigned OffBusW = CH_COUNT * (PIXEL_WIDTH + 1);

    logic [OffBusW-1:0] off_act_d, off_act_q;
    logic [OffBusW-1:0] off_shd_d, off_shd_q;
`endif

    // Sync delay line, matched to the channel pipeline depth.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < Latency; i++) begin
                sync_q[i] <= SyncReset;
            end
        end else begin
            sync_q[0] <= '{de: de_i, hs: hs_i, vs: vs_i};
            for (int i = 1; i < Latency; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign de_o = sync_q[Latency-1].de;
    assign hs_o = sync_q[Latency-1].hs;
    assign vs_o = sync_q[Latency-1].vs;

    assign vs_rise = vs_i & ~vs_in_q;

    // Active set only moves on a frame start, so a frame never sees two gains.
    always_comb begin
        coe_act_d = coe_act_q;
        coe_shd_d = coe_shd_q;
        pend_d    = pend_q;
`ifdef MULT_V3_OFFSET_EN
        off_act_d = off_act_q;
        off_shd_d = off_shd_q;
`endif
        if (coe_upd_i && vs_rise) begin
            coe_act_d = coe_i;
            coe_shd_d = coe_i;
            pend_d    = 1'b0;
`ifdef MULT_V3_OFFSET_EN
            off_act_d = off_i;
            off_shd_d = off_i;
`endif
        end else begin
            if (vs_rise && pend_q) begin
                coe_act_d = coe_shd_q;
                pend_d    = 1'b0;
`ifdef MULT_V3_OFFSET_EN
                off_act_d = off_shd_q;
`endif
            end
            if (coe_upd_i) begin
                coe_shd_d = coe_i;
                pend_d    = 1'b1;
`ifdef MULT_V3_OFFSET_EN
                off_shd_d = off_i;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            vs_in_q   <= 1'b0;
            coe_act_q <= {CH_COUNT{CoeUnity}};
            coe_shd_q <= {CH_COUNT{CoeUnity}};
            pend_q    <= 1'b0;
`ifdef MULT_V3_OFFSET_EN
            off_act_q <= '0;
            off_shd_q <= '0;
`endif
        end else begin
            vs_in_q   <= vs_i;
            coe_act_q <= coe_act_d;
            coe_shd_q <= coe_shd_d;
            pend_q    <= pend_d;
`ifdef MULT_V3_OFFSET_EN
            off_act_q <= off_act_d;
            off_shd_q <= off_shd_d;
`endif
        end
    end

    assign coe_pend_o = pend_q;

    for (genvar c = 0; c < CH_COUNT; c++) begin : g_ch
        mult_v3_ch #(
            .PIXEL_WIDTH (PIXEL_WIDTH),
            .COE_WIDTH   (COE_WIDTH),
            .COE_FRAC    (COE_FRAC)
        ) u_ch (
            .clk   (clk),
            .rst   (rst),
            .pix_i (di_i[c*PIXEL_WIDTH +: PIXEL_WIDTH]),
            .coe_i (coe_act_q[c*COE_WIDTH +: COE_WIDTH]),
`ifdef MULT_V3_OFFSET_EN
            .off_i (off_act_q[c*(PIXEL_WIDTH+1) +: (PIXEL_WIDTH+1)]),
`endif
            .pix_o (do_o[c*PIXEL_WIDTH +: PIXEL_WIDTH]),
            .sat_o (ch_sat[c])
        );
    end

    // Frame boundary is taken from the output-side vs so the count covers exactly the
    // pixels that left this frame.
    assign vs_fall = vs_out_q & ~vs_o;
    assign sat_hit = de_o & (|ch_sat);
    assign acc_inc = (sat_hit && (acc_q != '1)) ? acc_q + SAT_CNT_WIDTH'(1) : acc_q;

    always_comb begin
        acc_d     = acc_inc;
        sat_cnt_d = sat_cnt_q;
        sat_vld_d = 1'b0;
        if (vs_fall) begin
            acc_d     = '0;
            sat_cnt_d = acc_inc;
            sat_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            vs_out_q  <= 1'b0;
            acc_q     <= '0;
            sat_cnt_q <= '0;
            sat_vld_q <= 1'b0;
        end else begin
            vs_out_q  <= vs_o;
            acc_q     <= acc_d;
            sat_cnt_q <= sat_cnt_d;
            sat_vld_q <= sat_vld_d;
        end
    end

    assign sat_cnt_o = sat_cnt_q;
    assign sat_vld_o = sat_vld_q;

endmodule

// File: tb/tb_mult_v3.sv
// Scoreboard bench for mult_v3: a second instance with a 4-bit saturation counter checks
// the sticky limit. Define MULT_V3_OFFSET_EN to also exercise the offset path.
module tb_mult_v3;

    localparam int CF    = 10;
    localparam int UNITY = 1 << CF;

    typedef struct packed {
        logic [23:0] d;
        logic        de;
        logic        hs;
        logic        vs;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [47:0] coe;
    logic        coe_upd;
    logic [23:0] di;
    logic        de, hs, vs;
`ifdef MULT_V3_OFFSET_EN
    logic [26:0] off;
`endif

    logic [23:0] do_a, do_b;
    logic        de_a, hs_a, vs_a, pend_a, vld_a;
    logic        de_b, hs_b, vs_b, pend_b, vld_b;
    logic [23:0] cnt_a;
    logic [3:0]  cnt_b;

    always #5 clk = ~clk;

    mult_v3 u_dut_a (
        .clk(clk), .rst(rst), .coe_i(coe), .coe_upd_i(coe_upd), .di_i(di),
        .de_i(de), .hs_i(hs), .vs_i(vs),
`ifdef MULT_V3_OFFSET_EN
        .off_i(off),
`endif
        .do_o(do_a), .de_o(de_a), .hs_o(hs_a), .vs_o(vs_a), .coe_pend_o(pend_a),
        .sat_cnt_o(cnt_a), .sat_vld_o(vld_a)
    );

    mult_v3 #(.SAT_CNT_WIDTH(4)) u_dut_b (
        .clk(clk), .rst(rst), .coe_i(coe), .coe_upd_i(coe_upd), .di_i(di),
        .de_i(de), .hs_i(hs), .vs_i(vs),
`ifdef MULT_V3_OFFSET_EN
        .off_i(off),
`endif
        .do_o(do_b), .de_o(de_b), .hs_o(hs_b), .vs_o(vs_b), .coe_pend_o(pend_b),
        .sat_cnt_o(cnt_b), .sat_vld_o(vld_b)
    );

    int   n_pass = 0;
    int   n_total = 0;
    exp_t sb_q[$];
    exp_t mon_e;

    int m_act[3], m_shd[3], m_oact[3], m_oshd[3];
    bit m_pend, m_vs_prev;
    int m_sat;
    int px_x, px_mode;
    int n_hi1, n_hi2;
    bit pend_after_upd, pend_after_rise;

    function automatic void model_pix(output exp_t e, output bit sat_any);
        longint p, r, s;
        sat_any = 1'b0;
        e.de = de;
        e.hs = hs;
        e.vs = vs;
        e.d  = '0;
        for (int c = 0; c < 3; c++) begin
            p = longint'(di[c*8 +: 8]) * longint'(m_act[c]);
            r = (p + longint'(UNITY / 2)) >>> CF;
            s = r + longint'(m_oact[c]);
            if (s < 0) begin
                e.d[c*8 +: 8] = 8'd0;
                sat_any = 1'b1;
            end else if (s > 255) begin
                e.d[c*8 +: 8] = 8'd255;
                sat_any = 1'b1;
            end else begin
                e.d[c*8 +: 8] = 8'(s);
            end
        end
    endfunction

    task automatic tick();
        exp_t e;
        bit   sa;
        bit   rise;
        model_pix(e, sa);
        sb_q.push_back(e);
        if (rst && de && sa) m_sat++;
        if (!rst) begin
            for (int c = 0; c < 3; c++) begin
                m_act[c] = UNITY; m_shd[c] = UNITY; m_oact[c] = 0; m_oshd[c] = 0;
            end
            m_pend = 0; m_vs_prev = 0; m_sat = 0;
        end else begin
            rise = vs && !m_vs_prev;
            if (coe_upd && rise) begin
                for (int c = 0; c < 3; c++) begin
                    m_act[c] = int'(coe[c*16 +: 16]);
                    m_shd[c] = m_act[c];
`ifdef MULT_V3_OFFSET_EN
                    m_oact[c] = int'($signed(off[c*9 +: 9]));
                    m_oshd[c] = m_oact[c];
`endif
                end
                m_pend = 0;
            end else begin
                if (rise && m_pend) begin
                    for (int c = 0; c < 3; c++) begin
                        m_act[c] = m_shd[c]; m_oact[c] = m_oshd[c];
                    end
                    m_pend = 0;
                end
                if (coe_upd) begin
                    for (int c = 0; c < 3; c++) begin
                        m_shd[c] = int'(coe[c*16 +: 16]);
`ifdef MULT_V3_OFFSET_EN
                        m_oshd[c] = int'($signed(off[c*9 +: 9]));
`endif
                    end
                    m_pend = 1;
                end
            end
            m_vs_prev = vs;
        end
        @(posedge clk);
        #1;
        if (!rst) begin
            sb_q.delete();
            repeat (3) sb_q.push_back('{d: 24'd0, de: 1'b0, hs: 1'b1, vs: 1'b0});
        end
    endtask

    // Output scoreboard: entry for cycle j is due after the third following edge.
    always @(negedge clk) begin
        if (sb_q.size() == 4) begin
            mon_e = sb_q.pop_front();
            n_total++;
            if ({do_a, de_a, hs_a, vs_a} !== mon_e)
                $display("FAIL pipe_a t=%0t got %h want %h", $time,
                         {do_a, de_a, hs_a, vs_a}, mon_e);
            else n_pass++;
            n_total++;
            if ({do_b, de_b, hs_b, vs_b} !== mon_e)
                $display("FAIL pipe_b t=%0t got %h want %h", $time,
                         {do_b, de_b, hs_b, vs_b}, mon_e);
            else n_pass++;
        end
    end

    task automatic set_pix();
        logic [7:0] v;
        if (px_mode == 0) begin
            v  = 8'(4090 + px_x);
            di = {v, v, v};
        end else begin
            di = {8'(px_x + 170), 8'(px_x + 85), 8'(px_x)};
        end
    endtask

    task automatic blank(int n);
        de = 1'b0;
        hs = 1'b1;
        for (int i = 0; i < n; i++) begin
            set_pix();
            tick();
        end
    endtask

    task automatic line(int ppl, int de_per);
        blank(4);
        hs = 1'b0;
        for (int i = 0; i < ppl; i++) begin
            de = ((i % de_per) == 0);
            set_pix();
            if (de && di[15:8] >= 8'd128) n_hi1++;
            if (de && di[23:16] >= 8'd171) n_hi2++;
            tick();
            px_x++;
        end
        de = 1'b0;
        hs = 1'b1;
    endtask

    task automatic frame(int lines, int ppl, int de_per, int upd_line, logic [47:0] upd_coe,
                         bit upd_at_rise);
        m_sat = 0; n_hi1 = 0; n_hi2 = 0;
        vs = 1'b0;
        blank(4);
        vs = 1'b1;
        if (upd_at_rise) begin
            coe = upd_coe;
            coe_upd = 1'b1;
        end
        blank(1);
        coe_upd = 1'b0;
        pend_after_rise = pend_a;
        blank(1);
        for (int l = 0; l < lines; l++) begin
            if (l == upd_line) begin
                coe = upd_coe;
                coe_upd = 1'b1;
                blank(1);
                coe_upd = 1'b0;
                pend_after_upd = pend_a;
            end
            line(ppl, de_per);
        end
        vs = 1'b0;
        blank(2);
    endtask

    task automatic pulse_upd(logic [47:0] c);
        coe = c;
        coe_upd = 1'b1;
        blank(1);
        coe_upd = 1'b0;
    endtask

    task automatic wait_strobe(output bit found, output logic [23:0] ca, output logic [3:0] cb);
        found = 1'b0;
        ca = 'x;
        cb = 'x;
        for (int i = 0; i < 12 && !found; i++) begin
            blank(1);
            if (vld_a) begin
                found = 1'b1;
                ca = cnt_a;
                cb = cnt_b;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        blank(2);
        rst = 1'b1;
        n_total++; if (do_a !== 24'd0) $display("FAIL rst_do got %h want 0", do_a); else n_pass++;
        n_total++; if (de_a !== 1'b0) $display("FAIL rst_de got %b want 0", de_a); else n_pass++;
        n_total++; if (hs_a !== 1'b1) $display("FAIL rst_hs got %b want 1", hs_a); else n_pass++;
        n_total++; if (vs_a !== 1'b0) $display("FAIL rst_vs got %b want 0", vs_a); else n_pass++;
        n_total++; if (pend_a !== 1'b0) $display("FAIL rst_pend got %b want 0", pend_a);
        else n_pass++;
        n_total++; if (cnt_a !== 24'd0) $display("FAIL rst_cnt got %0d want 0", cnt_a);
        else n_pass++;
        n_total++; if (vld_a !== 1'b0) $display("FAIL rst_vld got %b want 0", vld_a); else n_pass++;
    endtask

    task automatic test_unity();
        bit found; logic [23:0] ca; logic [3:0] cb;
        px_mode = 0; px_x = 0;
        frame(6, 40, 2, -1, '0, 1'b0);
        wait_strobe(found, ca, cb);
        n_total++; if (found !== 1'b1) $display("FAIL unity_strobe got %b want 1", found);
        else n_pass++;
        n_total++; if (ca !== 24'd0) $display("FAIL unity_cnt got %0d want 0", ca); else n_pass++;
        n_total++; if (cb !== 4'd0) $display("FAIL unity_cnt4 got %0d want 0", cb); else n_pass++;
        blank(1);
        n_total++; if (vld_a !== 1'b0) $display("FAIL unity_vld_pulse got %b want 0", vld_a);
        else n_pass++;
    endtask

    task automatic test_rounding();
        bit found; logic [23:0] ca; logic [3:0] cb;
        vs = 1'b0;
        blank(2);
        pulse_upd({16'h0400, 16'h0600, 16'h0200});
        n_total++; if (pend_a !== 1'b1) $display("FAIL round_pend got %b want 1", pend_a);
        else n_pass++;
        vs = 1'b1;
        blank(1);
        n_total++; if (pend_a !== 1'b0) $display("FAIL round_pend_clr got %b want 0", pend_a);
        else n_pass++;
        hs = 1'b0; de = 1'b1;
        di = {8'd100, 8'd5, 8'd3}; tick();
        di = {8'd100, 8'd5, 8'd2}; tick();
        de = 1'b0; tick();
        n_total++;
        if (do_a !== {8'd100, 8'd8, 8'd2}) $display("FAIL round_3_5 got %h want 640802", do_a);
        else n_pass++;
        tick();
        n_total++;
        if (do_a !== {8'd100, 8'd8, 8'd1}) $display("FAIL round_2 got %h want 640801", do_a);
        else n_pass++;
        vs = 1'b0;
        blank(2);
        wait_strobe(found, ca, cb);
        n_total++; if (found !== 1'b1 || ca !== 24'd0)
            $display("FAIL round_strobe got %b/%0d want 1/0", found, ca);
        else n_pass++;
    endtask

    task automatic test_saturation();
        bit found; logic [23:0] ca; logic [3:0] cb;
        vs = 1'b0;
        pulse_upd({16'h0400, 16'h0800, 16'h0400});
        px_mode = 1; px_x = 0;
        frame(8, 64, 1, -1, '0, 1'b0);
        wait_strobe(found, ca, cb);
        n_total++; if (found !== 1'b1) $display("FAIL sat_strobe got %b want 1", found);
        else n_pass++;
        n_total++; if (ca !== 24'(n_hi1)) $display("FAIL sat_cnt got %0d want %0d", ca, n_hi1);
        else n_pass++;
        n_total++; if (ca !== 24'(m_sat)) $display("FAIL sat_cnt_model got %0d want %0d", ca, m_sat);
        else n_pass++;
        n_total++; if (cb !== ((n_hi1 > 15) ? 4'd15 : 4'(n_hi1)))
            $display("FAIL sat_cnt4 got %0d want %0d", cb, (n_hi1 > 15) ? 15 : n_hi1);
        else n_pass++;
    endtask

    task automatic test_frame_update();
        bit found; logic [23:0] ca; logic [3:0] cb;
        px_mode = 1;
        frame(8, 32, 1, 5, {16'h0400, 16'h0400, 16'h0200}, 1'b0);
        n_total++; if (pend_after_upd !== 1'b1)
            $display("FAIL upd_pend got %b want 1", pend_after_upd);
        else n_pass++;
        wait_strobe(found, ca, cb);
        // Old gain (ch1 x2.0) held for the whole frame despite the mid-frame request.
        n_total++; if (found !== 1'b1 || ca !== 24'(n_hi1))
            $display("FAIL upd_old_gain got %b/%0d want 1/%0d", found, ca, n_hi1);
        else n_pass++;
        n_total++; if (pend_a !== 1'b1) $display("FAIL upd_pend_hold got %b want 1", pend_a);
        else n_pass++;
        frame(4, 32, 1, -1, '0, 1'b0);
        n_total++; if (pend_after_rise !== 1'b0)
            $display("FAIL upd_pend_clr got %b want 0", pend_after_rise);
        else n_pass++;
        wait_strobe(found, ca, cb);
        n_total++; if (found !== 1'b1 || ca !== 24'd0)
            $display("FAIL upd_new_gain got %b/%0d want 1/0", found, ca);
        else n_pass++;
    endtask

    task automatic test_same_cycle();
        bit found; logic [23:0] ca; logic [3:0] cb;
        px_mode = 1;
        frame(4, 32, 1, -1, {16'h0600, 16'h0400, 16'h0400}, 1'b1);
        n_total++; if (pend_after_rise !== 1'b0)
            $display("FAIL same_pend got %b want 0", pend_after_rise);
        else n_pass++;
        wait_strobe(found, ca, cb);
        n_total++; if (found !== 1'b1 || ca !== 24'(n_hi2))
            $display("FAIL same_cnt got %b/%0d want 1/%0d", found, ca, n_hi2);
        else n_pass++;
    endtask

    task automatic test_reset_midframe();
        bit found; logic [23:0] ca; logic [3:0] cb;
        px_mode = 1;
        vs = 1'b0;
        blank(4);
        vs = 1'b1;
        blank(2);
        line(32, 1);
        line(32, 1);
        pulse_upd({16'h0200, 16'h0200, 16'h0200});
        n_total++; if (pend_a !== 1'b1) $display("FAIL mid_pend got %b want 1", pend_a);
        else n_pass++;
        line(16, 1);
        hs = 1'b0; de = 1'b1;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        n_total++;
        if ({do_a, de_a, hs_a, vs_a, pend_a} !== {24'd0, 1'b0, 1'b1, 1'b0, 1'b0})
            $display("FAIL mid_rst got %h want 0000004", {do_a, de_a, hs_a, vs_a, pend_a});
        else n_pass++;
        di = {8'd200, 8'd200, 8'd200};
        tick();
        de = 1'b0;
        hs = 1'b1;
        tick(); tick();
        n_total++; if (do_a !== 24'hC8C8C8) $display("FAIL mid_unity got %h want c8c8c8", do_a);
        else n_pass++;
        vs = 1'b0;
        blank(2);
        wait_strobe(found, ca, cb);
        n_total++; if (found !== 1'b1 || ca !== 24'd0)
            $display("FAIL mid_strobe got %b/%0d want 1/0", found, ca);
        else n_pass++;
    endtask

`ifdef MULT_V3_OFFSET_EN
    task automatic test_offset();
        bit found; logic [23:0] ca; logic [3:0] cb;
        logic [8:0] offs [2];
        logic [7:0] pix [2];
        logic [7:0] want [2];
        offs[0] = 9'h1EC; pix[0] = 8'd10;  want[0] = 8'd0;
        offs[1] = 9'h014; pix[1] = 8'd250; want[1] = 8'd255;
        for (int k = 0; k < 2; k++) begin
            vs = 1'b0;
            off = {offs[k], 18'd0};
            pulse_upd({16'h0400, 16'h0400, 16'h0400});
            vs = 1'b1;
            blank(1);
            hs = 1'b0; de = 1'b1;
            di = {pix[k], pix[k], pix[k]};
            tick();
            de = 1'b0;
            tick(); tick();
            n_total++; if (do_a !== {want[k], pix[k], pix[k]})
                $display("FAIL off_clamp%0d got %h want %h", k, do_a, {want[k], pix[k], pix[k]});
            else n_pass++;
            vs = 1'b0;
            blank(2);
            wait_strobe(found, ca, cb);
            n_total++; if (found !== 1'b1 || ca !== 24'd1)
                $display("FAIL off_cnt%0d got %b/%0d want 1/1", k, found, ca);
            else n_pass++;
        end
    endtask
`endif

    initial begin
        rst = 1'b0; coe = '0; coe_upd = 1'b0; di = '0; de = 1'b0; hs = 1'b1; vs = 1'b0;
`ifdef MULT_V3_OFFSET_EN
        off = '0;
`endif
        px_x = 0; px_mode = 0; m_sat = 0;
        test_reset();
        test_unity();
        test_rounding();
        test_saturation();
        test_frame_update();
        test_same_cycle();
        test_reset_midframe();
`ifdef MULT_V3_OFFSET_EN
        test_offset();
`endif
        blank(4);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mult_v3.md
Name: mult_v3

Overview:
- Per-channel fixed-point gain stage for the video pixel stream (de/hs/vs framing). Generalises mult_v2.
- Parametrised channel count and coefficient format; adds round-half-up and saturation.
- Coefficient updates are frame-synchronous, so there is no mid-frame tearing.
- Reports a per-frame count of saturated pixels.
- Sits between colour-processing filters, e.g. white balance or gain, ahead of the output monitor.

Parameters:
- PIXEL_WIDTH, 8, bits per channel.
- CH_COUNT, 3, number of channels. ch0 sits at the LSB (B, then G, then R).
- COE_WIDTH, 16, unsigned coefficient width.
- COE_FRAC, 10, fractional bits of the coefficient. (1<<COE_FRAC) is 1.0. Legal range 0..COE_WIDTH-1.
- SAT_CNT_WIDTH, 24, width of the saturation counter.

Ports:
- clk  in  1  pixel clock.
- rst  in  1  reset; synchronous, active-low.
- coe_i  in  CH_COUNT*COE_WIDTH  coefficients; ch0 at the LSB.
- coe_upd_i  in  1  one-cycle request to take coe_i.
- di_i  in  CH_COUNT*PIXEL_WIDTH  pixel in.
- de_i  in  1  data enable.
- hs_i  in  1  line blank (high = blank).
- vs_i  in  1  frame active (high).
- do_o  out  CH_COUNT*PIXEL_WIDTH  pixel out.
- de_o  out  1  delayed de_i.
- hs_o  out  1  delayed hs_i.
- vs_o  out  1  delayed vs_i.
- coe_pend_o  out  1  an update is waiting for the next frame start.
- sat_cnt_o  out  SAT_CNT_WIDTH  saturated-pixel count of the last frame.
- sat_vld_o  out  1  one-cycle strobe when sat_cnt_o is updated.

Behaviour:
- Reset (rst=0 at a clk edge):
  - do_o=0, de_o=0, hs_o=1, vs_o=0.
  - coe_pend_o=0, sat_cnt_o=0, sat_vld_o=0.
  - Pipeline contents: de=0, hs=1, vs=0.
  - Active and shadow coefficients are set to unity (1<<COE_FRAC).
  - Internal counter is cleared.
  - Reset mid-frame discards all in-flight pixels and the pending update.
- Latency: fixed 3 clk cycles. Data, de, hs and vs are delayed identically, with no dependence on de (de gaps pass through unchanged).
- Stage 1: register di_i and the active coefficients; compute the product p = pix*coe, width PIXEL_WIDTH+COE_WIDTH.
- Stage 2, rounding:
  - Compute r = (p + (1<<(COE_FRAC-1))) >> COE_FRAC.
  - When COE_FRAC=0 there is no rounding add.
  - Keep the full width, so there is no overflow.
- Stage 3, saturation: if r > 2^PIXEL_WIDTH-1, output 2^PIXEL_WIDTH-1 and set that channel's sat flag; otherwise output r[PIXEL_WIDTH-1:0].
- do_o is driven for every cycle regardless of de; the sat flag counts only when de is high at stage 3.
- Coefficient update:
  - coe_upd_i=1 copies coe_i into the shadow register and sets pending.
  - On a vs_i rising edge (registered vs_i was 0, vs_i is now 1) with pending=1, active is loaded from shadow and pending is cleared.
  - If coe_upd_i and the vs_i rise occur in the same cycle, coe_i loads straight into active and pending ends at 0.
  - A second coe_upd_i before the frame start overwrites the shadow; the last one wins.
  - A request while vs_i=1 waits for the next frame.
  - Active coefficients never change while vs_i is high.
- Saturation counter:
  - Increments by 1 per stage-3 de pixel in which any channel saturated.
  - Sticks at all-ones.
  - On a vs_o falling edge: sat_cnt_o takes the counter value (including the current cycle's increment), sat_vld_o=1 for one cycle, and the counter clears.
  - A frame with no saturation still produces a strobe, with the value 0.

Optional Feature:
- Macro: MULT_V3_OFFSET_EN.
- With the macro defined:
  - An extra input port, off_i  in  CH_COUNT*(PIXEL_WIDTH+1), carries signed per-channel offsets.
  - Offsets are shadowed and applied at frame start together with the coefficients, using the same coe_upd_i.
  - The offset is added to r in stage 2.
  - Stage 3 clamps to 0..2^PIXEL_WIDTH-1; both low and high clamps count as saturation.
  - Latency is still 3.
- Without the macro: off_i does not exist, and only the high clamp applies.

Decomposition:
- Package mult_v3_pkg:
  - function coe_unity(COE_FRAC).
  - function round_const(COE_FRAC).
  - Product/round width helper functions.
  - typedef for the stage-valid bundle {de, hs, vs}.
- Sub-module mult_v3_ch:
  - One channel's three-stage multiply/round/(offset)/saturate pipeline, outputting sat_flag.
  - Generated CH_COUNT times.
- The top level owns sync delays, coefficient shadow/pending logic and the saturation counter.

Test Plan:
- Unity gain: coe=0x400 on all channels, di=(4090+x)[7:0], x=0..599, DE period 2 → do_o equals di_i delayed 3 clk; de/hs/vs identical delayed copies; sat_cnt_o=0 with sat_vld_o at each frame end.
- Rounding: coe ch0=0x200 (0.5), pix 3 → 2; pix 2 → 1; coe 0x600 (1.5), pix 5 → 8 (7.5 rounds up).
- Saturation: coe ch1=0x800 (2.0), 600x600 frame, pixels 0..255 cycling → outputs ≥128 read 255; sat_cnt_o equals the number of pixels ≥128 in the frame; counter stuck at max with SAT_CNT_WIDTH=4.
- Frame-synchronous update:
  - coe_upd_i with coe ch0=0x200 pulsed at line 5 → current frame keeps the old gain; coe_pend_o=1 until the next vs rise, then outputs halve.
  - Simultaneous coe_upd_i and vs rise → applies in the same frame.
- Reset mid-frame: rst=0 for 1 clk at line 100 → next cycle do_o=0, de_o=0, hs_o=1, vs_o=0; coefficients back to 0x400; pending cleared.
- With MULT_V3_OFFSET_EN: off ch2=-20, coe 0x400, pix 10 → 0 and counted as saturated; off +20, pix 250 → 255 and counted.
